neuron_mac_layer: RTL and testbench

//  Fully-connected layer MAC stage, directly upstream of the activation block.

---
 rtl/neuron_mac_layer.sv | 137 +++++++++++++
 tb/tb_neuron_mac_layer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_layer.sv
// neuron_mac_layer
//   Fully-connected layer MAC stage feeding the activation block. One input
//   element x[k] arrives per accepted beat together with one weight per
//   neuron; all `size` neuron sums accumulate in parallel, each seeded with
//   its bias aligned to the product's fixed-point scale. When the last beat
//   is accepted the narrowed results are registered and held on out_data
//   until the downstream handshake completes.
//
// Configuration macro: MAC_SATURATE_EN
//   defined   : results clamp to the signed data_size range
//   undefined : results keep their low data_size bits (two's complement wrap)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (returns to IDLE, clears state)
//   start      begin an evaluation; sampled only in IDLE
//   bias       per-neuron bias lanes, captured on an accepted start
//   in_valid   in_data/in_weight valid
//   in_ready   beat accepted when high together with in_valid (ACCUM only)
//   in_data    input element x[k]
//   in_weight  w[i][k], lane i = bits [(i+1)*data_size-1 : i*data_size]
//   out_valid  out_data holds a finished result (DONE)
//   out_ready  downstream consumes the result
//   out_data   narrowed neuron sums, same lane order as in_weight
//   busy       high in ACCUM or DONE
module neuron_mac_layer #(
  parameter int data_size   = 16,
  parameter int size        = 3,
  parameter int input_count = 4,
  parameter int frac_bits   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [data_size*size-1:0] bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_size-1:0]      in_data,
  input  logic [data_size*size-1:0] in_weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [data_size*size-1:0] out_data,
  output logic                      busy
);

  // Wide enough for input_count full products plus the bias term.
  localparam int ACC_W  = 2*data_size + $clog2(input_count) + 1;
  localparam int PROD_W = 2*data_size;
  localparam int CNT_W  = $clog2(input_count + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt_p0;
  logic signed [ACC_W-1:0] acc_p0  [size];
  logic signed [ACC_W-1:0] acc_sum [size];
  logic signed [PROD_W-1:0] prod   [size];
  logic                    beat;
  logic                    last_beat;

  // Drop the fractional scale of the product and narrow to one lane.
  function automatic logic signed [data_size-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef MAC_SATURATE_EN
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(ACC_W-data_size+1){1'b0}}, {(data_size-1){1'b1}}};
    sat_min = {{(ACC_W-data_size+1){1'b1}}, {(data_size-1){1'b0}}};
    s = v >>> frac_bits;
    if (s > sat_max)      return sat_max[data_size-1:0];
    else if (s < sat_min) return sat_min[data_size-1:0];
    else                  return data_size'(s);
`else
    return data_size'(v >>> frac_bits);
`endif
  endfunction

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (cnt_p0 == CNT_W'(input_count - 1));

  // Stage p0 combinational: running sum including the current beat.
  always_comb begin
    for (int i = 0; i < size; i++) begin
      prod[i]    = $signed(in_data) * $signed(in_weight[i*data_size +: data_size]);
      acc_sum[i] = acc_p0[i] + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_ACCUM;
      S_ACCUM: if (last_beat) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: accumulators and beat count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      for (int i = 0; i < size; i++) acc_p0[i] <= '0;
    end else if (state == S_IDLE && start) begin
      cnt_p0 <= '0;
      for (int i = 0; i < size; i++)
        acc_p0[i] <= {{(ACC_W-data_size){bias[(i+1)*data_size-1]}},
                      bias[i*data_size +: data_size]} << frac_bits;
    end else if (beat) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
      for (int i = 0; i < size; i++) acc_p0[i] <= acc_sum[i];
    end
  end

  // Stage p1: result register, loaded from the sum that includes the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (last_beat) begin
      for (int i = 0; i < size; i++)
        out_data[i*data_size +: data_size] <= narrow(acc_sum[i]);
    end
  end

endmodule

// File: tb/tb_neuron_mac_layer.sv
module tb_neuron_mac_layer;

  localparam int DW = 16;
  localparam int NS = 3;
  localparam int NI = 4;
  localparam int FB = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DW*NS-1:0] bias;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [DW*NS-1:0] in_weight;
  logic             out_valid;
  logic             out_ready;
  logic [DW*NS-1:0] out_data;
  logic             busy;

  neuron_mac_layer #(.data_size(DW), .size(NS), .input_count(NI), .frac_bits(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = -100;
  int rdy_low = 0;
  logic [DW*NS-1:0] sb_q[$];
  logic [DW-1:0]    txs [NI];
  logic [DW*NS-1:0] tws [NI];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] narrow_ref(input longint r);
`ifdef MAC_SATURATE_EN
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
`endif
    return r[DW-1:0];
  endfunction

  // Real-valued sum in units of 2^-16, floored back to Q8.8.
  function automatic logic [DW*NS-1:0] model(input logic [DW*NS-1:0] b);
    logic [DW*NS-1:0] res;
    longint acc;
    logic [DW-1:0] lane;
    res = '0;
    for (int i = 0; i < NS; i++) begin
      lane = b[i*DW +: DW];
      acc = longint'($signed(lane)) * 256;
      for (int k = 0; k < NI; k++) begin
        lane = tws[k][i*DW +: DW];
        acc = acc + longint'($signed(txs[k])) * longint'($signed(lane));
      end
      res[i*DW +: DW] = narrow_ref(acc >>> FB);
    end
    return res;
  endfunction

  // Downstream ready: random, or forced low for rdy_low cycles.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_low > 0) begin
        out_ready = 1'b0;
        rdy_low--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit pending = 0;
    bit have_held = 0;
    logic [DW*NS-1:0] held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pending = 0;
        have_held = 0;
      end else if (out_valid) begin
        checks++;
        if (in_ready) begin
          errors++;
          $display("FAIL in_ready_in_done: in_ready=%0b required 0", in_ready);
        end
        if (!pending) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: out_data=%h with no result expected", out_data);
          end else if (out_data !== sb_q[0]) begin
            errors++;
            $display("FAIL result: out_data=%h required %h", out_data, sb_q[0]);
          end
          checks++;
          if (cyc != last_cyc) begin
            errors++;
            $display("FAIL latency: out_valid at cycle %0d required %0d", cyc, last_cyc);
          end
        end else begin
          checks++;
          if (out_data !== held) begin
            errors++;
            $display("FAIL stall_stable: out_data=%h required %h", out_data, held);
          end
        end
        held = out_data;
        have_held = 1;
        if (out_ready) begin
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          pending = 0;
        end else begin
          pending = 1;
        end
      end else if (have_held) begin
        checks++;
        if (out_data !== held) begin
          errors++;
          $display("FAIL hold_after_done: out_data=%h required %h", out_data, held);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL %s: in_ready=%b out_valid=%b busy=%b out_data=%h required 0 0 0 0",
               tag, in_ready, out_valid, busy, out_data);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  // Drive one evaluation from txs/tws. Runs on negedges.
  task automatic run_txn(input logic [DW*NS-1:0] b, input int gapmax, input bit mid_start,
                         input bit hold, input int nbeats, input bit expect_res);
    int gap;
    int n;
    wait_idle();
    if (expect_res) sb_q.push_back(model(b));
    start = 1'b1;
    bias = b;
    in_valid = $urandom_range(0, 1);
    @(negedge clk);
    start = 1'b0;
    bias = {$urandom, $urandom};
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accum_entry: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    for (int k = 0; k < nbeats; k++) begin
      in_valid = 1'b1;
      in_data = txs[k];
      in_weight = tws[k];
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      last_cyc = cyc;
      if (k == nbeats - 1 && hold) rdy_low = 6;
      @(negedge clk);
      gap = (k == nbeats - 1) ? 0 : $urandom_range(0, gapmax);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data = $urandom;
        in_weight = {$urandom, $urandom};
        start = mid_start && (g == 0);
        @(negedge clk);
        start = 1'b0;
      end
    end
    // Keep presenting garbage after the last beat; it must not be taken.
    in_valid = $urandom_range(0, 1);
    in_data = $urandom;
    in_weight = {$urandom, $urandom};
    start = mid_start;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic fill_const(input logic [DW-1:0] x, input logic [DW*NS-1:0] w);
    for (int k = 0; k < NI; k++) begin
      txs[k] = x;
      tws[k] = w;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = $urandom_range(0, 1);
    bias = {$urandom, $urandom};
    in_valid = $urandom_range(0, 1);
    in_data = $urandom;
    in_weight = {$urandom, $urandom};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_reset_outputs("reset");
      start = $urandom_range(0, 1);
      in_valid = $urandom_range(0, 1);
      in_data = $urandom;
    end
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;

    fill_const(16'h0100, 48'hFF00_0080_0100);
    run_txn(48'h0, 0, 0, 0, NI, 1);

    fill_const(16'h0000, 48'hFF00_0080_0100);
    run_txn(48'h0000_0000_0100, 0, 0, 0, NI, 1);

    fill_const(16'h0100, 48'hFF00_0080_0100);
    run_txn(48'h0, 3, 1, 1, NI, 1);

    fill_const(16'h7F00, 48'h7F00_7F00_7F00);
    run_txn(48'h0, 1, 0, 0, NI, 1);

    // Abort after two beats.
    fill_const(16'h0100, 48'hFF00_0080_0100);
    run_txn(48'h0, 0, 0, 0, 2, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort_idle");
    run_txn(48'h0, 2, 0, 0, NI, 1);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < NI; k++) begin
        txs[k] = $urandom;
        tws[k] = {$urandom, $urandom};
        if (t < 8) begin
          txs[k] = DW'($signed(txs[k][11:0]));
          tws[k] = {DW'($signed(tws[k][42:32])), DW'($signed(tws[k][26:16])), DW'($signed(tws[k][10:0]))};
        end
      end
      run_txn({$urandom, $urandom}, 3, $urandom_range(0, 1), $urandom_range(0, 1), NI, 1);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding required 0", sb_q.size());
    end
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
